mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the datapath's MAR/MDR memory interface.
//   Accepts read/write requests driven from MAR_out (address) and MDR_out (write data).
//   Returns read data as Mdatain to the MDR input mux after a programmable number of wait states.
//   Uses a four-phase request/ready handshake. Sits between the CPU top and the word-addressed RAM.
// PARAMETERS
//   DEPTH        512  number of 32-bit words; addresses >= DEPTH are out of range
//   ADDR_W       9    index width into the array, = clog2(DEPTH)
//   WAIT_STATES  2    extra cycles between request acceptance and array access; 0..15 legal
// PORTS
//   clk         in   1   single clock; all state updates on rising edge
//   clr         in   1   reset, asynchronous, active-high
//   mem_read    in   1   read request; held high until mem_ready seen
//   mem_write   in   1   write request; held high until mem_ready seen
//   address     in   32  word address (MAR_out)
//   data_in     in   32  write data (MDR_out)
//   data_out    out  32  read data (Mdatain to MDR mux)
//   mem_ready   out  1   request complete; held while the request is held
//   busy        out  1   high in WAIT and ACCESS states
//   err         out  1   qualifies mem_ready: bad address or read+write both high
// BEHAVIOUR
//   Reset (async, clr=1): state=IDLE, data_out=0, mem_ready=0, busy=0, err=0, wait count=0.
//   - RAM contents are not cleared by clr.
//   States: IDLE -> WAIT -> ACCESS -> DONE -> IDLE.
//   IDLE
//   - On a clk edge with (mem_read ^ mem_write): latch address, data_in and op.
//   - Load wait count = WAIT_STATES; go to WAIT, or to ACCESS if WAIT_STATES=0.
//   - mem_read & mem_write both high: go directly to DONE with err=1; no array access.
//   WAIT
//   - busy=1; decrement count; go to ACCESS when count reaches 1.
//   - Inputs are ignored; latched values are used.
//   ACCESS (one cycle)
//   - Latched address < DEPTH:
//     - write: array[addr] <= data. data_out is unchanged.
//     - read: data_out <= array[addr].
//   - Latched address >= DEPTH: no write; read sets data_out=0; err <= 1.
//   - Next state is DONE.
//   DONE
//   - mem_ready=1, err valid, busy=0.
//   - Stay while the originally requested line (read or write) stays high.
//   - When it drops: go to IDLE and clear mem_ready and err on that same edge.
//   Latency
//   - Request first sampled at edge n; mem_ready visible after edge n+WAIT_STATES+2.
//   - Example: WAIT_STATES=2, request at edge 0 -> ready after edge 4.
//   - A back-to-back request costs one extra IDLE cycle.
//   data_out
//   - Holds the last read value until the next successful read, bad-address read or clr.
//   Address width: bits [ADDR_W-1:0] index the array; the full 32-bit value is used for the range check.
//   Reset mid-operation: any state -> IDLE immediately.
//   - A write still in WAIT is discarded.
//   - A write in ACCESS at the clr edge does not occur.
//   Request dropped early (in WAIT or ACCESS): the transaction still completes.
//   - DONE then exits on the next edge because the request is already low.
//   Request raised again while in DONE: ignored until IDLE is re-entered.
// STRUCTURE
//   Shared package mem_pkg:
//   - state encoding (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, DONE=2'd3)
//   - WORD_W=32
//   - MEM_OP_READ / MEM_OP_WRITE constants
//   Sub-module mem_array: single-port synchronous RAM (DEPTH x 32, we, addr, din, dout).
//   - No reset; optional $readmemh init for simulation.
//   mem_responder holds the FSM, wait counter, request latches and error logic.
// TESTING
//   1. clr=1 mid-WAIT of a write to addr 5 -> outputs all 0, state IDLE; a later read of 5 returns prior contents.
//   2. WAIT_STATES=2: write 0xDEADBEEF to addr 10 -> mem_ready after edge 4; drop write; read 10 -> data_out=0xDEADBEEF, err=0.
//   3. Read address 0x0000_0200 (=DEPTH) -> mem_ready=1, err=1, data_out=0; write to 0x200 leaves array[0] unchanged.
//   4. mem_read=mem_write=1 at addr 3 -> mem_ready=1, err=1 next cycle; array[3] unchanged.
//   5. WAIT_STATES=0: read addr 7 holding 0x1234 -> mem_ready after edge 2; busy high exactly one cycle.
//   6. Hold mem_read in DONE for 5 cycles -> mem_ready stays 1, no re-access; drop -> ready=0 next edge, new request accepted.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MAR/MDR memory responder.
package mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  typedef enum logic {
    MEM_OP_READ  = 1'b0,
    MEM_OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/ready memory bus between the CPU datapath (master) and the responder (slave).
interface mem_responder_if;

  logic                        mem_read;
  logic                        mem_write;
  logic [mem_pkg::WORD_W-1:0]  address;
  logic [mem_pkg::WORD_W-1:0]  data_in;
  logic [mem_pkg::WORD_W-1:0]  data_out;
  logic                        mem_ready;
  logic                        busy;
  logic                        err;

  modport master (
    output mem_read, mem_write, address, data_in,
    input  data_out, mem_ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, address, data_in,
    output data_out, mem_ready, busy, err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; contents survive reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_din,
  output logic [WORD_W-1:0] o_dout
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
    o_dout <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a request, waits WAIT_STATES cycles, accesses the
// array once, then holds mem_ready/err until the requester drops its line.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            clr,
  mem_responder_if.slave  bus
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  mem_state_t        r_state, w_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [WORD_W-1:0] r_addr, r_wdata, r_data_out;
  mem_op_t           r_op;
  logic              r_conflict, r_ready, r_err;
  logic              w_accept, w_conflict, w_bad, w_req_held, w_we;
  logic [WORD_W-1:0] w_rdata;

  assign w_bad = !(r_addr < DEPTH);
  assign w_we  = (r_state == ACCESS) && (r_op == MEM_OP_WRITE) && !w_bad && !clr;

  assign w_req_held = r_conflict ? (bus.mem_read | bus.mem_write)
                    : (r_op == MEM_OP_READ) ? bus.mem_read : bus.mem_write;

  mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (r_addr[ADDR_W-1:0]),
    .i_din  (r_wdata),
    .o_dout (w_rdata)
  );

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_conflict = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.mem_read && bus.mem_write) begin
          w_conflict = 1'b1;
          w_next     = DONE;
        end else if (bus.mem_read ^ bus.mem_write) begin
          w_accept   = 1'b1;
          w_cnt_next = LP_WAIT;
          w_next     = (LP_WAIT == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = ACCESS;
      end
      ACCESS: w_next = DONE;
      DONE: begin
        if (r_ready && !w_req_held) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op       <= MEM_OP_READ;
      r_conflict <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= bus.address;
        r_wdata    <= bus.data_in;
        r_op       <= bus.mem_write ? MEM_OP_WRITE : MEM_OP_READ;
        r_conflict <= 1'b0;
      end
      if (w_conflict) begin
        r_conflict <= 1'b1;
        r_ready    <= 1'b1;
        r_err      <= 1'b1;
      end
      // First DONE cycle waits for the synchronous RAM output; ready rises with the data.
      if (r_state == DONE && !r_ready) begin
        r_ready <= 1'b1;
        r_err   <= w_bad;
        if (r_op == MEM_OP_READ) r_data_out <= w_bad ? '0 : w_rdata;
      end
      if (r_state == DONE && w_next == IDLE) begin
        r_ready <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.mem_ready = r_ready;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state == WAIT) || (r_state == ACCESS);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(2)) u_dut2 (
    .clk (clk), .clr (clr), .bus (bus2)
  );

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(0)) u_dut0 (
    .clk (clk), .clr (clr), .bus (bus0)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.address = a; bus0.data_in = wd;
    end else begin
      bus2.mem_read = rd; bus2.mem_write = wr; bus2.address = a; bus2.data_in = wd;
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? bus0.mem_ready : bus2.mem_ready;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus0.busy : bus2.busy;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? bus0.err : bus2.err;
  endfunction

  function automatic logic [31:0] dout_of(input int d);
    return (d == 0) ? bus0.data_out : bus2.data_out;
  endfunction

  // lat = number of edges from the first sampling edge until ready is seen, plus one
  task automatic xfer(input int d, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output int nbusy);
    drive(d, rd, wr, a, wd);
    lat   = 99;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy_of(d)) nbusy++;
      if (rdy_of(d)) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_req(input int d, input string tag);
    drive(d, 1'b0, 1'b0, '0, '0);
    tick();
    expect_eq({tag, "_rdy_drop"}, 32'(rdy_of(d)), 32'd0);
    expect_eq({tag, "_err_drop"}, 32'(err_of(d)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nb;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    expect_eq("rst_dout", dout_of(2), 32'd0);
    expect_eq("rst_rdy",  32'(rdy_of(2)),  32'd0);
    expect_eq("rst_busy", 32'(busy_of(2)), 32'd0);
    expect_eq("rst_err",  32'(err_of(2)),  32'd0);
    clr = 1'b0;

    // Seed addr 5
    xfer(2, 1'b0, 1'b1, 32'd5, 32'h1111_1111, lat, nb);
    expect_eq("seed5_lat", 32'(lat), 32'd5);
    release_req(2, "seed5");

    // 1: reset during WAIT of a write discards it
    drive(2, 1'b0, 1'b1, 32'd5, 32'h5555_5555);
    tick();
    tick();
    expect_eq("t1_busy_wait", 32'(busy_of(2)), 32'd1);
    #2 clr = 1'b1;
    #1;
    expect_eq("t1_rdy",  32'(rdy_of(2)),  32'd0);
    expect_eq("t1_busy", 32'(busy_of(2)), 32'd0);
    expect_eq("t1_err",  32'(err_of(2)),  32'd0);
    expect_eq("t1_dout", dout_of(2), 32'd0);
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    clr = 1'b0;
    tick();
    xfer(2, 1'b1, 1'b0, 32'd5, '0, lat, nb);
    expect_eq("t1_rd5", dout_of(2), 32'h1111_1111);
    release_req(2, "t1");

    // 2: write then read back with two wait states
    xfer(2, 1'b0, 1'b1, 32'd10, 32'hDEAD_BEEF, lat, nb);
    expect_eq("t2_wr_lat",  32'(lat), 32'd5);
    expect_eq("t2_wr_busy", 32'(nb), 32'd3);
    expect_eq("t2_wr_err",  32'(err_of(2)), 32'd0);
    expect_eq("t2_dout_hold", dout_of(2), 32'h1111_1111);
    release_req(2, "t2w");
    xfer(2, 1'b1, 1'b0, 32'd10, '0, lat, nb);
    expect_eq("t2_rd_lat",  32'(lat), 32'd5);
    expect_eq("t2_rd_data", dout_of(2), 32'hDEAD_BEEF);
    expect_eq("t2_rd_err",  32'(err_of(2)), 32'd0);
    release_req(2, "t2r");

    // 3: out-of-range address
    xfer(2, 1'b0, 1'b1, 32'd0, 32'hCAFE_F00D, lat, nb);
    release_req(2, "t3seed");
    xfer(2, 1'b1, 1'b0, 32'h0000_0200, '0, lat, nb);
    expect_eq("t3_rd_lat",  32'(lat), 32'd5);
    expect_eq("t3_rd_err",  32'(err_of(2)), 32'd1);
    expect_eq("t3_rd_dout", dout_of(2), 32'd0);
    release_req(2, "t3r");
    xfer(2, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, lat, nb);
    expect_eq("t3_wr_err", 32'(err_of(2)), 32'd1);
    release_req(2, "t3w");
    xfer(2, 1'b1, 1'b0, 32'd0, '0, lat, nb);
    expect_eq("t3_arr0", dout_of(2), 32'hCAFE_F00D);
    release_req(2, "t3c");

    // 4: read and write together
    xfer(2, 1'b0, 1'b1, 32'd3, 32'h3333_3333, lat, nb);
    release_req(2, "t4seed");
    xfer(2, 1'b1, 1'b1, 32'd3, 32'hBAD0_BAD0, lat, nb);
    expect_eq("t4_lat",  32'(lat), 32'd1);
    expect_eq("t4_err",  32'(err_of(2)), 32'd1);
    expect_eq("t4_busy", 32'(nb), 32'd0);
    release_req(2, "t4");
    xfer(2, 1'b1, 1'b0, 32'd3, '0, lat, nb);
    expect_eq("t4_arr3", dout_of(2), 32'h3333_3333);
    release_req(2, "t4c");

    // 5: zero wait states
    xfer(0, 1'b0, 1'b1, 32'd7, 32'h0000_1234, lat, nb);
    expect_eq("t5_wr_lat", 32'(lat), 32'd3);
    release_req(0, "t5w");
    xfer(0, 1'b1, 1'b0, 32'd7, '0, lat, nb);
    expect_eq("t5_rd_lat",  32'(lat), 32'd3);
    expect_eq("t5_busy",    32'(nb), 32'd1);
    expect_eq("t5_rd_data", dout_of(0), 32'h0000_1234);
    release_req(0, "t5r");

    // 6: hold the read in DONE, then back-to-back request
    xfer(2, 1'b1, 1'b0, 32'd10, '0, lat, nb);
    expect_eq("t6_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_eq($sformatf("t6_hold_rdy%0d", i),  32'(rdy_of(2)),  32'd1);
      expect_eq($sformatf("t6_hold_busy%0d", i), 32'(busy_of(2)), 32'd0);
    end
    expect_eq("t6_hold_data", dout_of(2), 32'hDEAD_BEEF);
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    expect_eq("t6_rdy_drop", 32'(rdy_of(2)), 32'd0);
    xfer(2, 1'b1, 1'b0, 32'd5, '0, lat, nb);
    expect_eq("t6_b2b_lat",  32'(lat), 32'd5);
    expect_eq("t6_b2b_data", dout_of(2), 32'h1111_1111);
    release_req(2, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
